// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one digit lit at a time with dead-time
// gaps, shadow-register loads applied only at frame start.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int GAP        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank,
  output logic [3:0]                nibble,
  output logic [NUM_DIGITS-1:0]     anode_n,
  output logic                      pending,
  output logic                      frame_done
);

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int VW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {S_GAP, S_SHOW} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;

  logic [VW-1:0]         act_val, act_val_nx;
  logic [VW-1:0]         pend_val, pend_val_nx;
  logic [NUM_DIGITS-1:0] act_blank, act_blank_nx;
  logic [NUM_DIGITS-1:0] pend_blank, pend_blank_nx;
  logic                  pend_nx;

  logic [3:0]            nib_nx;
  logic [NUM_DIGITS-1:0] an_nx;
  logic                  fd_nx;

  logic gap_end, show_end, apply;

  assign gap_end  = (state == S_GAP) && (cnt == GAP_LAST);
  assign show_end = (state == S_SHOW) && (cnt == DWELL_LAST);
  // Shadow moves to active at the start of digit 0, or whenever idle.
  assign apply    = !en || (gap_end && (idx == '0));

  // State, counters, shadow/active registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_GAP;
      cnt        <= '0;
      idx        <= '0;
      act_val    <= '0;
      pend_val   <= '0;
      act_blank  <= '1;
      pend_blank <= '1;
      pending    <= 1'b0;
      nibble     <= 4'h0;
      anode_n    <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      act_val    <= act_val_nx;
      pend_val   <= pend_val_nx;
      act_blank  <= act_blank_nx;
      pend_blank <= pend_blank_nx;
      pending    <= pend_nx;
      nibble     <= nib_nx;
      anode_n    <= an_nx;
      frame_done <= fd_nx;
    end
  end

  // Scan sequencing: GAP -> SHOW per digit, forced idle when disabled
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    if (!en) begin
      state_nx = S_GAP;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      unique case (state)
        S_GAP: begin
          if (gap_end) begin
            state_nx = S_SHOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (show_end) begin
            state_nx = S_GAP;
            cnt_nx   = '0;
            idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = S_GAP;
      endcase
    end
  end

  // Load handshake: capture into shadow, bypass when coincident with apply
  always_comb begin
    act_val_nx    = act_val;
    act_blank_nx  = act_blank;
    pend_val_nx   = load ? value : pend_val;
    pend_blank_nx = load ? blank : pend_blank;
    pend_nx       = pending;
    if (apply) begin
      if (load) begin
        act_val_nx   = value;
        act_blank_nx = blank;
      end else if (pending) begin
        act_val_nx   = pend_val;
        act_blank_nx = pend_blank;
      end
      pend_nx = 1'b0;
    end else if (load) begin
      pend_nx = 1'b1;
    end
  end

  // Output values for the next cycle, derived from the next scan state
  always_comb begin
    nib_nx = nibble;
    if (en && gap_end) nib_nx = act_val_nx[idx*4 +: 4];
    an_nx = '1;
    if (state_nx == S_SHOW) an_nx[idx_nx] = act_blank_nx[idx_nx];
    fd_nx = en && show_end && (idx == IDX_LAST);
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model compared every
// cycle, plus hand-computed literal expectations along the directed flow.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int D = 4;
  localparam int G = 2;
  localparam int P = N * (D + G);

  logic        clk = 0;
  logic        rst_n = 0;
  logic        en = 0;
  logic        load = 0;
  logic [15:0] value = 0;
  logic [3:0]  blank = 0;
  logic [3:0]  nibble;
  logic [3:0]  anode_n;
  logic        pending;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL(D), .GAP(G)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .load(load),
    .value(value),
    .blank(blank),
    .nibble(nibble),
    .anode_n(anode_n),
    .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Model: position within the frame; each digit slot is G dark cycles
  // followed by D lit cycles.
  int          pos = 0;
  int          npos, slot, off;
  logic [15:0] m_av = 0, m_pv = 0;
  logic [3:0]  m_ab = '1, m_pb = '1;
  logic        m_pend = 0;
  logic [3:0]  m_nib = 0;
  logic [3:0]  m_an = '1;
  logic        m_fd = 0;
  bit          m_apply;

  always @(posedge clk) begin
    if (!rst_n) begin
      pos = 0; m_av = 0; m_pv = 0; m_ab = '1; m_pb = '1;
      m_pend = 0; m_nib = 0; m_an = '1; m_fd = 0;
    end else begin
      npos = en ? ((pos + 1) % P) : 0;
      m_fd = en && (pos == P - 1);
      m_apply = !en || (npos == G);
      if (load) begin m_pv = value; m_pb = blank; end
      if (m_apply) begin
        if (load) begin m_av = value; m_ab = blank; end
        else if (m_pend) begin m_av = m_pv; m_ab = m_pb; end
        m_pend = 0;
      end else if (load) begin
        m_pend = 1;
      end
      slot = npos / (G + D);
      off  = npos % (G + D);
      if (en && off == G) m_nib = m_av[slot*4 +: 4];
      m_an = '1;
      if (off >= G && !m_ab[slot]) m_an[slot] = 1'b0;
      pos = npos;
    end
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_nibble", {12'h0, nibble}, {12'h0, m_nib});
      chk("model_anode", {12'h0, anode_n}, {12'h0, m_an});
      chk("model_pending", {15'h0, pending}, {15'h0, m_pend});
      chk("model_frame_done", {15'h0, frame_done}, {15'h0, m_fd});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic goto(int p);
    int n = 0;
    while (pos != p && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (pos != p) begin
      failures++;
      $display("FAIL goto: pos %0d expected %0d", pos, p);
    end
  endtask

  int fd_cnt;

  initial begin
    tick();
    started = 1;
    tick();
    tick();
    chk("reset_anode", {12'h0, anode_n}, 16'h000F);
    chk("reset_nibble", {12'h0, nibble}, 16'h0000);
    chk("reset_pending", {15'h0, pending}, 16'h0000);
    chk("reset_fd", {15'h0, frame_done}, 16'h0000);

    // Basic scan of 3A7F
    rst_n = 1; en = 1; load = 1; value = 16'h3A7F; blank = 4'h0;
    tick();
    load = 0;
    chk("s1_pending", {15'h0, pending}, 16'h0001);
    chk("s1_gap0", {12'h0, anode_n}, 16'h000F);
    tick();
    chk("s1_an0", {12'h0, anode_n}, 16'h000E);
    chk("s1_nib0", {12'h0, nibble}, 16'h000F);
    chk("s1_pend_clr", {15'h0, pending}, 16'h0000);
    repeat (3) tick();
    chk("s1_an0_last", {12'h0, anode_n}, 16'h000E);
    tick();
    chk("s1_gap1", {12'h0, anode_n}, 16'h000F);
    repeat (2) tick();
    chk("s1_an1", {12'h0, anode_n}, 16'h000D);
    chk("s1_nib1", {12'h0, nibble}, 16'h0007);
    repeat (6) tick();
    chk("s1_an2", {12'h0, anode_n}, 16'h000B);
    chk("s1_nib2", {12'h0, nibble}, 16'h000A);
    repeat (6) tick();
    chk("s1_an3", {12'h0, anode_n}, 16'h0007);
    chk("s1_nib3", {12'h0, nibble}, 16'h0003);
    repeat (4) tick();
    chk("s1_fd", {15'h0, frame_done}, 16'h0001);
    fd_cnt = 0;
    repeat (48) begin
      tick();
      if (frame_done) fd_cnt++;
    end
    chk("s1_fd_count", fd_cnt[15:0], 16'd2);

    // Mid-frame load while digit 2 is lit
    goto(14);
    load = 1; value = 16'h1234;
    tick();
    load = 0;
    chk("s2_pending", {15'h0, pending}, 16'h0001);
    chk("s2_old2", {12'h0, nibble}, 16'h000A);
    goto(20);
    chk("s2_old3", {12'h0, nibble}, 16'h0003);
    goto(1);
    chk("s2_pend_hold", {15'h0, pending}, 16'h0001);
    tick();
    chk("s2_pend_clr", {15'h0, pending}, 16'h0000);
    chk("s2_new0", {12'h0, nibble}, 16'h0004);
    goto(8);
    chk("s2_new1", {12'h0, nibble}, 16'h0003);

    // Blank mask 1010
    goto(10);
    load = 1; value = 16'h1234; blank = 4'b1010;
    tick();
    load = 0; blank = 4'h0;
    goto(2);
    chk("s3_an0", {12'h0, anode_n}, 16'h000E);
    chk("s3_nib0", {12'h0, nibble}, 16'h0004);
    goto(8);
    chk("s3_an1", {12'h0, anode_n}, 16'h000F);
    chk("s3_nib1", {12'h0, nibble}, 16'h0003);
    goto(14);
    chk("s3_an2", {12'h0, anode_n}, 16'h000B);
    goto(20);
    chk("s3_an3", {12'h0, anode_n}, 16'h000F);
    chk("s3_nib3", {12'h0, nibble}, 16'h0001);

    // Back-to-back loads
    goto(5);
    load = 1; value = 16'hAAAA;
    tick();
    load = 0;
    tick();
    load = 1; value = 16'hBBBB;
    tick();
    load = 0;
    chk("s4_pending", {15'h0, pending}, 16'h0001);
    goto(2);
    chk("s4_nib0", {12'h0, nibble}, 16'h000B);
    chk("s4_an0", {12'h0, anode_n}, 16'h000E);
    goto(20);
    chk("s4_nib3", {12'h0, nibble}, 16'h000B);

    // Load coincident with the apply edge
    goto(1);
    load = 1; value = 16'h0005;
    tick();
    load = 0;
    chk("s5_nib", {12'h0, nibble}, 16'h0005);
    chk("s5_pending", {15'h0, pending}, 16'h0000);
    chk("s5_an", {12'h0, anode_n}, 16'h000E);

    // Disable while digit 1 is lit, with a pending load outstanding
    goto(7);
    load = 1; value = 16'h9999;
    tick();
    load = 0;
    chk("s6_pending", {15'h0, pending}, 16'h0001);
    en = 0;
    tick();
    chk("s6_off", {12'h0, anode_n}, 16'h000F);
    chk("s6_applied", {15'h0, pending}, 16'h0000);
    repeat (3) tick();
    en = 1;
    tick();
    chk("s6_gap", {12'h0, anode_n}, 16'h000F);
    tick();
    chk("s6_relit", {12'h0, anode_n}, 16'h000E);
    chk("s6_nib", {12'h0, nibble}, 16'h0009);

    // Reset mid-SHOW of the last digit
    goto(21);
    rst_n = 0;
    tick();
    chk("s7_anode", {12'h0, anode_n}, 16'h000F);
    chk("s7_nibble", {12'h0, nibble}, 16'h0000);
    chk("s7_pending", {15'h0, pending}, 16'h0000);
    fd_cnt = 0;
    repeat (5) begin
      tick();
      if (frame_done) fd_cnt++;
    end
    chk("s7_no_fd", fd_cnt[15:0], 16'd0);
    rst_n = 1;
    repeat (30) tick();
    chk("s7_dark", {12'h0, anode_n}, 16'h000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one hexdigit decoder. It holds a multi-digit hex value and selects one digit at a time. It drives that digit's nibble to the shared decoder input and asserts the matching active-low anode. A dead-time gap between digits suppresses ghosting, and a shadow-register load handshake gives tear-free updates at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of scanned digits (>=2)
DWELL, 1000, clock cycles each digit is lit (>=1)
GAP, 16, clock cycles all anodes are off between digits (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
en  input  1  scan enable
load  input  1  one-cycle strobe: capture value/blank into pending shadow
value  input  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i]
blank  input  NUM_DIGITS  per-digit blank mask (1 = digit dark)
nibble  output  4  to shared hexdigit decoder input
anode_n  output  NUM_DIGITS  active-low digit enables
pending  output  1  load captured, not yet applied to display
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (rst_n). All outputs are registered.
- Reset (rst_n=0 at edge):
  - state=GAP, digit index=0, dwell/gap counter=0.
  - active and pending value=0, active and pending blank=all 1s.
  - nibble=0, anode_n=all 1s, pending=0, frame_done=0.
  - Reset mid-frame aborts the scan immediately, with no partial frame_done.
- States: GAP, SHOW.
  - GAP: anode_n all 1s. The counter runs 0..GAP-1. On the edge where counter=GAP-1 and en=1: go to SHOW, counter cleared, nibble loaded with active digit[index].
  - SHOW: anode_n[index]=0 unless the active blank[index]=1; all other anode bits are 1. nibble is stable for the whole SHOW.
  - SHOW counter runs 0..DWELL-1. At DWELL-1: go to GAP and index increments. Index wraps NUM_DIGITS-1 -> 0.
- Timing: each digit is lit exactly DWELL cycles. Frame period = NUM_DIGITS*(DWELL+GAP) cycles.
- frame_done: high for exactly the one cycle following the edge that leaves SHOW of digit NUM_DIGITS-1.
- en=0:
  - On the next edge: state=GAP, index=0, counter=0, anode_n all 1s. Held there while en=0.
  - Any pending data is applied to the active registers on that edge, and every edge while en=0.
  - On en rising, the first digit lights after a full GAP.
- Load handshake:
  - load=1 captures value/blank into the pending registers and sets pending=1.
  - A new load while pending=1 overwrites the shadow; last write wins.
  - Apply point is the GAP->SHOW edge with index=0. Pending contents move to the active registers and pending clears.
  - Load on the same edge as an apply point: the incoming value/blank bypass straight to the active registers. That digit 0 shows the new data, and pending ends at 0.
  - The active value is never changed mid-frame, so there is no tearing.
- Counters are sized clog2 of max(DWELL,GAP); index is sized clog2(NUM_DIGITS). No other arithmetic.

Test Plan:
All scenarios use NUM_DIGITS=4, DWELL=4, GAP=2.
- Reset then en=1, load value=16'h3A7F, blank=0:
  - First SHOW begins 2 cycles after en. The anode_n sequence is 1110,1111,1101,1111,1011,1111,0111, each lit for 4 cycles.
  - nibble sequence is F,7,A,3.
  - frame_done pulses once every 24 cycles.
- Mid-frame load:
  - Load 16'h1234 while digit 2 is lit.
  - pending=1 until the next digit-0 GAP->SHOW edge, then 0.
  - Digits 2 and 3 still show old nibbles; the next frame shows 4,3,2,1.
- Load with blank=4'b1010:
  - After apply, anode_n stays 1111 during SHOW of digits 1 and 3.
  - Timing and nibble output are unchanged.
- Back-to-back loads:
  - 16'hAAAA, then 16'hBBBB two cycles later, both before the apply point.
  - Only B,B,B,B is ever displayed.
- Load coincident with apply edge:
  - load=1 with value=16'h0005 on the index-0 GAP->SHOW edge.
  - Digit 0 immediately shows 5, and pending=0 on the next cycle.
- Disruption:
  - Deassert en while digit 1 is lit: anode_n=1111 the next cycle.
  - Reassert en: digit 0 lights after 2 cycles.
  - Pulse rst_n=0 mid-SHOW: all outputs return to reset values on that edge, and no frame_done is produced.
